// File: rtl/pe_pkg.sv
// Shared types and geometry for the PE feeder: line/element sizes and the feeder FSM states.
// A line holds LINE_ELEMS halfword elements; element 0 sits in the most significant halfword.
package pe_pkg;

    localparam int unsigned ELEM_W     = 16;
    localparam int unsigned LINE_W     = 512;
    localparam int unsigned LINE_ELEMS = 32;
    localparam int unsigned ELEM_IDX_W = $clog2(LINE_ELEMS);
    localparam int unsigned RES_W      = 32;
    localparam int unsigned RES_IDX_W  = 8;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StFill,
        StStream
    } pe_state_e;

endpackage

// File: rtl/pe_feeder_if.sv
// Bundle of instruction, line-read, PE-stream and result signals around the PE feeder.
// master is the feeder side; slave is the surrounding system (memory, PE, instruction source).
interface pe_feeder_if #(
    parameter int unsigned LEN_W  = 8,
    parameter int unsigned ADDR_W = 11
);
    import pe_pkg::*;

    logic                 inst_vld;
    logic                 inst_rdy;
    logic [LEN_W-1:0]     inst_len;

    logic                 rd_en;
    logic [ADDR_W-1:0]    rd_addr;
    logic [LINE_W-1:0]    neuron_line;
    logic [LINE_W-1:0]    weight_line;

    logic [ELEM_W-1:0]    pe_neuron;
    logic [ELEM_W-1:0]    pe_weight;
    logic [1:0]           pe_ctl;
    logic                 pe_vld;

    logic [RES_W-1:0]     pe_result;
    logic                 pe_vld_o;

    logic                 res_vld;
    logic [RES_W-1:0]     res_data;
    logic [RES_IDX_W-1:0] res_idx;

    modport master (
        input  inst_vld, inst_len, neuron_line, weight_line, pe_result, pe_vld_o,
        output inst_rdy, rd_en, rd_addr, pe_neuron, pe_weight, pe_ctl, pe_vld,
        output res_vld, res_data, res_idx
    );

    modport slave (
        output inst_vld, inst_len, neuron_line, weight_line, pe_result, pe_vld_o,
        input  inst_rdy, rd_en, rd_addr, pe_neuron, pe_weight, pe_ctl, pe_vld,
        input  res_vld, res_data, res_idx
    );

endinterface

// File: rtl/pe_line_buf.sv
// Holds one fetched neuron/weight line pair and selects the element currently being streamed.
module pe_line_buf
    import pe_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ld_en_i,
    input  logic [LINE_W-1:0]     neuron_line_i,
    input  logic [LINE_W-1:0]     weight_line_i,
    input  logic [ELEM_IDX_W-1:0] elem_idx_i,
    output logic [ELEM_W-1:0]     neuron_o,
    output logic [ELEM_W-1:0]     weight_o
);

    logic [LINE_ELEMS-1:0][ELEM_W-1:0] neuron_q;
    logic [LINE_ELEMS-1:0][ELEM_W-1:0] weight_q;
    logic [ELEM_IDX_W-1:0]             slot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neuron_q <= '0;
            weight_q <= '0;
        end else if (ld_en_i) begin
            neuron_q <= neuron_line_i;
            weight_q <= weight_line_i;
        end
    end

    // Element 0 is the top halfword, so the packed slot runs opposite to the element index.
    assign slot     = ELEM_IDX_W'(LINE_ELEMS - 1) - elem_idx_i;
    assign neuron_o = neuron_q[slot];
    assign weight_o = weight_q[slot];

endmodule

// File: rtl/pe_feeder.sv
// Accepts multi-line instructions, fetches lines and streams their elements serially to the PE,
// prefetching the next line so consecutive groups flow without a bubble; forwards PE results.
module pe_feeder
    import pe_pkg::*;
#(
    parameter int unsigned LEN_W   = 8,
    parameter int unsigned ADDR_W  = 11,
    parameter int unsigned MAX_OUT = 4
) (
    input logic         clk,
    input logic         rst_n,
    pe_feeder_if.master bus
);

    localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);
    localparam logic [ELEM_IDX_W-1:0] ELEM_LAST     = ELEM_IDX_W'(LINE_ELEMS - 1);
    localparam logic [ELEM_IDX_W-1:0] ELEM_PRE_LAST = ELEM_IDX_W'(LINE_ELEMS - 2);
    localparam logic [ELEM_IDX_W-1:0] ELEM_PREFETCH = ELEM_IDX_W'(LINE_ELEMS - 3);

    pe_state_e             state_q, state_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [LEN_W-1:0]      grp_q, grp_d;
    logic [ELEM_IDX_W-1:0] elem_q, elem_d;
    logic [ADDR_W-1:0]     line_ptr_q, line_ptr_d;
    logic [ADDR_W-1:0]     rd_addr_q, rd_addr_d;
    logic                  rd_en_q, rd_en_d;
    logic                  pe_vld_q, pe_vld_d;
    logic [1:0]            pe_ctl_q, pe_ctl_d;
    logic [CNT_W-1:0]      out_cnt_q, out_cnt_d;
    logic                  res_vld_q, res_vld_d;
    logic [RES_W-1:0]      res_data_q, res_data_d;
    logic [RES_IDX_W-1:0]  res_idx_q, res_idx_d;

    logic                  inst_rdy;
    logic                  start;
    logic                  last_grp;
    logic                  buf_ld;
    logic [ELEM_W-1:0]     buf_neuron;
    logic [ELEM_W-1:0]     buf_weight;

    assign inst_rdy = (state_q == StIdle) && (out_cnt_q < CNT_W'(MAX_OUT));
    // Zero-length instructions complete the handshake but never start a stream.
    assign start    = bus.inst_vld && inst_rdy && (bus.inst_len != '0);
    assign last_grp = (grp_q == len_q - LEN_W'(1));

    // Load on FILL, and at the final element of a non-last group when the prefetched line lands.
    assign buf_ld = (state_q == StFill) ||
                    ((state_q == StStream) && (elem_q == ELEM_LAST) && !last_grp);

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        grp_d      = grp_q;
        elem_d     = elem_q;
        line_ptr_d = line_ptr_q;
        rd_en_d    = 1'b0;
        rd_addr_d  = '0;
        pe_vld_d   = 1'b0;
        pe_ctl_d   = 2'b00;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StFetch;
                    len_d      = bus.inst_len;
                    rd_en_d    = 1'b1;
                    rd_addr_d  = line_ptr_q;
                    line_ptr_d = line_ptr_q + ADDR_W'(1);
                end
            end
            StFetch: begin
                state_d = StFill;
            end
            StFill: begin
                state_d  = StStream;
                grp_d    = '0;
                elem_d   = '0;
                pe_vld_d = 1'b1;
                pe_ctl_d = 2'b01;
            end
            StStream: begin
                if (elem_q == ELEM_LAST) begin
                    if (last_grp) begin
                        state_d = StIdle;
                    end else begin
                        grp_d    = grp_q + LEN_W'(1);
                        elem_d   = '0;
                        pe_vld_d = 1'b1;
                    end
                end else begin
                    elem_d      = elem_q + ELEM_IDX_W'(1);
                    pe_vld_d    = 1'b1;
                    pe_ctl_d[1] = last_grp && (elem_q == ELEM_PRE_LAST);
                    // Registered, so the request appears while the stream is at element 30.
                    if ((elem_q == ELEM_PREFETCH) && !last_grp) begin
                        rd_en_d    = 1'b1;
                        rd_addr_d  = line_ptr_q;
                        line_ptr_d = line_ptr_q + ADDR_W'(1);
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        out_cnt_d = out_cnt_q;
        if (start && !bus.pe_vld_o) begin
            out_cnt_d = out_cnt_q + CNT_W'(1);
        end else if (!start && bus.pe_vld_o && (out_cnt_q != '0)) begin
            out_cnt_d = out_cnt_q - CNT_W'(1);
        end
    end

    always_comb begin
        res_vld_d  = bus.pe_vld_o;
        res_data_d = bus.pe_vld_o ? bus.pe_result : '0;
        res_idx_d  = bus.pe_vld_o ? res_idx_q + RES_IDX_W'(1) : res_idx_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            len_q      <= '0;
            grp_q      <= '0;
            elem_q     <= '0;
            line_ptr_q <= '0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            pe_vld_q   <= 1'b0;
            pe_ctl_q   <= 2'b00;
            out_cnt_q  <= '0;
            res_vld_q  <= 1'b0;
            res_data_q <= '0;
            res_idx_q  <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            grp_q      <= grp_d;
            elem_q     <= elem_d;
            line_ptr_q <= line_ptr_d;
            rd_en_q    <= rd_en_d;
            rd_addr_q  <= rd_addr_d;
            pe_vld_q   <= pe_vld_d;
            pe_ctl_q   <= pe_ctl_d;
            out_cnt_q  <= out_cnt_d;
            res_vld_q  <= res_vld_d;
            res_data_q <= res_data_d;
            res_idx_q  <= res_idx_d;
        end
    end

    pe_line_buf u_line_buf (
        .clk           (clk),
        .rst_n         (rst_n),
        .ld_en_i       (buf_ld),
        .neuron_line_i (bus.neuron_line),
        .weight_line_i (bus.weight_line),
        .elem_idx_i    (elem_q),
        .neuron_o      (buf_neuron),
        .weight_o      (buf_weight)
    );

    assign bus.inst_rdy  = inst_rdy;
    assign bus.rd_en     = rd_en_q;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.pe_vld    = pe_vld_q;
    assign bus.pe_ctl    = pe_ctl_q;
    assign bus.pe_neuron = pe_vld_q ? buf_neuron : '0;
    assign bus.pe_weight = pe_vld_q ? buf_weight : '0;
    assign bus.res_vld   = res_vld_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_idx   = res_idx_q;

endmodule
